exdes_icrc_chk_sched: RTL and testbench
=======================================

EXDES_ICRC_CHK_SCHED -- requirements
Module: exdes_icrc_chk_sched

Interface
REQ-001 SHALL have parameter C_PKT_NUM_WIDTH, default 3; tag width, giving a pool of 2^C_PKT_NUM_WIDTH outstanding packets.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  512  receive packet data from the MAC.
- s_tkeep  in  64  byte enables.
- s_tvalid  in  1  beat valid.
- s_tlast  in  1  last beat of the packet.
- s_tready  out  1  beat accept.
- c_data  out  512  data to the ICRC calculator.
- c_keep  out  64  byte enables to the calculator.
- c_valid  out  1  beat valid to the calculator.
- c_first  out  1  first beat of the packet.
- c_last  out  1  last beat of the packet.
- c_pkt  out  C_PKT_NUM_WIDTH  tag of the current packet.
- r_pkt  in  C_PKT_NUM_WIDTH  tag of the returned result.
- r_err  in  1  ICRC mismatch; meaningful only when r_valid is high.
- r_valid  in  1  result strobe for the last beat.
- v_valid  out  1  verdict valid.
- v_ready  in  1  verdict accept.
- v_pass  out  1  1 = ICRC good.
- v_pkt  out  C_PKT_NUM_WIDTH  tag of the verdict.
- unexp  out  1  sticky flag: result arrived for a tag that is not outstanding.
- pkt_cnt  out  32  count of verdicts released.
- err_cnt  out  32  count of failed verdicts released.

Function
REQ-003 Beat acceptance SHALL be s_tvalid & s_tready.
REQ-004 Receive FSM SHALL have two states, SOP and MID.
- SOP -> MID on an accepted beat with s_tlast=0.
- MID -> SOP on an accepted beat with s_tlast=1.
- SOP stays SOP on an accepted single-beat packet.
REQ-005 s_tready SHALL be 0 only in state SOP while outstanding count = 2^C_PKT_NUM_WIDTH; it SHALL be 1 in all other cases, so a packet is never stalled mid-stream.
REQ-006 On each accepted SOP beat, the block SHALL allocate tag = wr_ptr, increment wr_ptr modulo 2^C_PKT_NUM_WIDTH, and hold that tag for every beat of the packet.
REQ-007 Calculator outputs (c_data, c_keep, c_valid, c_first, c_last, c_pkt) SHALL be registered copies of the accepted beat, with exactly 1-cycle latency.
- c_valid SHALL be 0 when no beat is accepted.
- c_first SHALL be 1 on the SOP beat only.
REQ-008 Per-tag table SHALL hold three bits per tag: busy, done, err.
- Allocation sets busy and clears done and err.
- r_valid on a busy tag sets done and sets err to r_err.
REQ-009 r_valid on a tag that is not busy, or already done, SHALL leave the table unchanged and set unexp to 1 until reset.
REQ-010 Verdicts SHALL be released in allocation order from rd_ptr, regardless of result return order.
- v_valid = done[rd_ptr].
- v_pass = ~err[rd_ptr].
- v_pkt = rd_ptr.
- v_valid, v_pass and v_pkt SHALL be held stable until v_ready.
REQ-011 On v_valid & v_ready, the block SHALL clear busy and done for rd_ptr, increment rd_ptr modulo 2^C_PKT_NUM_WIDTH, increment pkt_cnt, and increment err_cnt if v_pass = 0.
REQ-012 Outstanding count SHALL span 0..2^C_PKT_NUM_WIDTH (width C_PKT_NUM_WIDTH+1).
- Allocation and release in the same cycle SHALL leave the count unchanged.
- A tag freed in cycle N SHALL be allocatable in cycle N+1.
REQ-013 If r_valid for tag T and release of tag T occur in the same cycle, release SHALL use the pre-update table values (not yet done), so no release occurs that cycle.
REQ-014 pkt_cnt and err_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-015 With the calculator's 4-cycle pipeline, the minimum latency from the s_tlast accept to v_valid SHALL be 1 + 4 + 1 = 6 cycles.

Reset
REQ-016 On rst_n=0 the block SHALL asynchronously clear:
- FSM to SOP; wr_ptr, rd_ptr and outstanding count to 0.
- All busy, done and err bits.
- c_valid, c_first, c_last, v_valid, unexp, pkt_cnt and err_cnt to 0.
- c_data, c_keep and c_pkt to 0.
REQ-017 s_tready SHALL be 1 during and immediately after reset.
REQ-018 Reset asserted mid-packet or mid-handshake SHALL abandon all in-flight packets with no verdict issued; the upstream source is responsible for discarding the partial packet.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (SOP, MID), the 512/64 data and keep widths, and the counter width 32.
REQ-020 The per-tag table and in-order release logic SHALL be one sub-module, exdes_icrc_tag_tbl; the FSM and calculator feed remain in the top module.

Verification
REQ-021 Single-beat packet, s_tkeep=64'hFFFF_FFFF_FFFF_FFFF, r_valid with r_pkt=0 and r_err=0 five cycles after c_valid -> v_valid=1, v_pass=1, v_pkt=0; pkt_cnt=1; err_cnt=0.
REQ-022 Eight 3-beat packets back-to-back with no results returned -> tags 0..7 issued on c_pkt; s_tready=0 on the ninth SOP beat. After one verdict is accepted -> s_tready=1 the next cycle and the ninth packet receives tag 0.
REQ-023 Results returned out of order for tags 2, 0, 1, with r_err=1 on tag 0 -> verdicts released in order 0 (v_pass=0), 1, 2; err_cnt=1.
REQ-024 v_ready held at 0 for 10 cycles with v_valid=1 -> v_valid, v_pass and v_pkt stable throughout; counters unchanged until the handshake.
REQ-025 r_valid for tag 5 while only tags 0..1 are busy -> unexp=1 and remains 1; the table is unchanged.
REQ-026 rst_n asserted low during the middle beat of a packet with tag 3 outstanding -> all outputs at reset values immediately; the next packet receives tag 0.

Source files
------------

// File: rtl/exdes_icrc_chk_sched_pkg.sv
// Shared definitions for the ICRC check scheduler.
// Holds the receive FSM state encoding, the data/keep bus widths, the
// statistics counter width and a saturating increment helper.
package exdes_icrc_chk_sched_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int CNT_W  = 32;

  typedef enum logic {
    ST_SOP = 1'b0,
    ST_MID = 1'b1
  } rx_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/exdes_icrc_chk_sched_if.sv
// Signal bundle for the ICRC check scheduler.
//   s_*  : receive stream from the MAC (data, keep, valid, last, ready)
//   c_*  : registered beat feed to the ICRC calculator, tagged with c_pkt
//   r_*  : result strobe returned by the calculator for a tag
//   v_*  : in-order verdict handshake
//   unexp, pkt_cnt, err_cnt : status and statistics
// slave  : the scheduler side
// master : the environment side (MAC, calculator, verdict consumer)
interface exdes_icrc_chk_sched_if #(
  parameter int C_PKT_NUM_WIDTH = 3
) ();

  logic [exdes_icrc_chk_sched_pkg::DATA_W-1:0] s_tdata;
  logic [exdes_icrc_chk_sched_pkg::KEEP_W-1:0] s_tkeep;
  logic                                        s_tvalid;
  logic                                        s_tlast;
  logic                                        s_tready;

  logic [exdes_icrc_chk_sched_pkg::DATA_W-1:0] c_data;
  logic [exdes_icrc_chk_sched_pkg::KEEP_W-1:0] c_keep;
  logic                                        c_valid;
  logic                                        c_first;
  logic                                        c_last;
  logic [C_PKT_NUM_WIDTH-1:0]                  c_pkt;

  logic [C_PKT_NUM_WIDTH-1:0]                  r_pkt;
  logic                                        r_err;
  logic                                        r_valid;

  logic                                        v_valid;
  logic                                        v_ready;
  logic                                        v_pass;
  logic [C_PKT_NUM_WIDTH-1:0]                  v_pkt;

  logic                                        unexp;
  logic [exdes_icrc_chk_sched_pkg::CNT_W-1:0]  pkt_cnt;
  logic [exdes_icrc_chk_sched_pkg::CNT_W-1:0]  err_cnt;

  modport slave (
    input  s_tdata, s_tkeep, s_tvalid, s_tlast,
    output s_tready,
    output c_data, c_keep, c_valid, c_first, c_last, c_pkt,
    input  r_pkt, r_err, r_valid,
    output v_valid, v_pass, v_pkt,
    input  v_ready,
    output unexp, pkt_cnt, err_cnt
  );

  modport master (
    output s_tdata, s_tkeep, s_tvalid, s_tlast,
    input  s_tready,
    input  c_data, c_keep, c_valid, c_first, c_last, c_pkt,
    output r_pkt, r_err, r_valid,
    input  v_valid, v_pass, v_pkt,
    output v_ready,
    input  unexp, pkt_cnt, err_cnt
  );

endinterface

// File: rtl/exdes_icrc_tag_tbl.sv
// Per-tag status table and in-order verdict release.
// Ports:
//   alloc/alloc_tag         : new packet takes a tag (sets busy, clears done/err)
//   r_valid/r_pkt/r_err     : calculator result for a tag
//   v_valid/v_ready/v_pass/v_pkt : verdict for the oldest outstanding tag
//   full                    : every tag is outstanding
//   unexp                   : sticky, a result hit a free or already-done tag
//   pkt_cnt/err_cnt         : saturating verdict statistics
module exdes_icrc_tag_tbl
  import exdes_icrc_chk_sched_pkg::*;
#(
  parameter int C_PKT_NUM_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc,
  input  logic [C_PKT_NUM_WIDTH-1:0] alloc_tag,
  input  logic                       r_valid,
  input  logic [C_PKT_NUM_WIDTH-1:0] r_pkt,
  input  logic                       r_err,
  input  logic                       v_ready,
  output logic                       full,
  output logic                       v_valid,
  output logic                       v_pass,
  output logic [C_PKT_NUM_WIDTH-1:0] v_pkt,
  output logic                       unexp,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int POOL = 1 << C_PKT_NUM_WIDTH;

  logic [POOL-1:0]            busy_q, busy_d;
  logic [POOL-1:0]            done_q, done_d;
  logic [POOL-1:0]            err_q, err_d;
  logic [C_PKT_NUM_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PKT_NUM_WIDTH:0]   out_cnt_q, out_cnt_d;
  logic                       unexp_q, unexp_d;
  logic [CNT_W-1:0]           pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]           err_cnt_q, err_cnt_d;
  logic                       rel;

  assign full    = (out_cnt_q == (C_PKT_NUM_WIDTH+1)'(POOL));
  assign v_valid = done_q[rd_ptr_q];
  assign v_pass  = ~err_q[rd_ptr_q];
  assign v_pkt   = rd_ptr_q;
  assign unexp   = unexp_q;
  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;

  // Release looks only at registered state, so a result landing on the
  // head tag this cycle is released no earlier than next cycle.
  assign rel = v_valid & v_ready;

  always_comb begin
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rd_ptr_d  = rd_ptr_q;
    out_cnt_d = out_cnt_q;
    unexp_d   = unexp_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;

    if (r_valid) begin
      if (busy_q[r_pkt] && !done_q[r_pkt]) begin
        done_d[r_pkt] = 1'b1;
        err_d[r_pkt]  = r_err;
      end else begin
        unexp_d = 1'b1;
      end
    end

    if (rel) begin
      busy_d[rd_ptr_q] = 1'b0;
      done_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
      pkt_cnt_d        = sat_inc(pkt_cnt_q);
      if (err_q[rd_ptr_q]) err_cnt_d = sat_inc(err_cnt_q);
    end

    // A tag can only be allocated while free, so it never collides with
    // the head being released or with a legal result in the same cycle.
    if (alloc) begin
      busy_d[alloc_tag] = 1'b1;
      done_d[alloc_tag] = 1'b0;
      err_d[alloc_tag]  = 1'b0;
    end

    case ({alloc, rel})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rd_ptr_q  <= '0;
      out_cnt_q <= '0;
      unexp_q   <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_ptr_q  <= rd_ptr_d;
      out_cnt_q <= out_cnt_d;
      unexp_q   <= unexp_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: rtl/exdes_icrc_chk_sched.sv
// ICRC check scheduler top.
// Accepts packets from the MAC, tags each one from a pool of
// 2^C_PKT_NUM_WIDTH, forwards beats to the ICRC calculator one cycle later,
// collects out-of-order results and releases verdicts in arrival order.
// Ports: clk, rst_n (async active-low), bus (slave side of the interface).
//
// state  | meaning
// -------+----------------------------------------------------------
// ST_SOP | waiting for the first beat of a packet (may stall when full)
// ST_MID | inside a packet; beats always accepted until s_tlast
module exdes_icrc_chk_sched
  import exdes_icrc_chk_sched_pkg::*;
#(
  parameter int C_PKT_NUM_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  exdes_icrc_chk_sched_if.slave  bus
);

  rx_state_e                  state_q, state_d;
  logic [C_PKT_NUM_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PKT_NUM_WIDTH-1:0] cur_tag_q, cur_tag_d;

  logic [DATA_W-1:0]          c_data_q, c_data_d;
  logic [KEEP_W-1:0]          c_keep_q, c_keep_d;
  logic                       c_valid_q, c_valid_d;
  logic                       c_first_q, c_first_d;
  logic                       c_last_q, c_last_d;
  logic [C_PKT_NUM_WIDTH-1:0] c_pkt_q, c_pkt_d;

  logic                       full;
  logic                       s_tready;
  logic                       accept;
  logic                       sop_acc;
  logic [C_PKT_NUM_WIDTH-1:0] beat_tag;

  // Stall only at a packet boundary, never mid-packet.
  assign s_tready = !((state_q == ST_SOP) && full);
  assign accept   = bus.s_tvalid & s_tready;
  assign sop_acc  = accept & (state_q == ST_SOP);
  assign beat_tag = (state_q == ST_SOP) ? wr_ptr_q : cur_tag_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cur_tag_d = cur_tag_q;
    c_data_d  = c_data_q;
    c_keep_d  = c_keep_q;
    c_pkt_d   = c_pkt_q;
    c_valid_d = accept;
    c_first_d = sop_acc;
    c_last_d  = accept & bus.s_tlast;

    if (accept) begin
      c_data_d = bus.s_tdata;
      c_keep_d = bus.s_tkeep;
      c_pkt_d  = beat_tag;
      state_d  = bus.s_tlast ? ST_SOP : ST_MID;
    end

    if (sop_acc) begin
      cur_tag_d = wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SOP;
      wr_ptr_q  <= '0;
      cur_tag_q <= '0;
      c_data_q  <= '0;
      c_keep_q  <= '0;
      c_valid_q <= 1'b0;
      c_first_q <= 1'b0;
      c_last_q  <= 1'b0;
      c_pkt_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cur_tag_q <= cur_tag_d;
      c_data_q  <= c_data_d;
      c_keep_q  <= c_keep_d;
      c_valid_q <= c_valid_d;
      c_first_q <= c_first_d;
      c_last_q  <= c_last_d;
      c_pkt_q   <= c_pkt_d;
    end
  end

  assign bus.s_tready = s_tready;
  assign bus.c_data   = c_data_q;
  assign bus.c_keep   = c_keep_q;
  assign bus.c_valid  = c_valid_q;
  assign bus.c_first  = c_first_q;
  assign bus.c_last   = c_last_q;
  assign bus.c_pkt    = c_pkt_q;

  exdes_icrc_tag_tbl #(
    .C_PKT_NUM_WIDTH (C_PKT_NUM_WIDTH)
  ) u_tag_tbl (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (sop_acc),
    .alloc_tag (wr_ptr_q),
    .r_valid   (bus.r_valid),
    .r_pkt     (bus.r_pkt),
    .r_err     (bus.r_err),
    .v_ready   (bus.v_ready),
    .full      (full),
    .v_valid   (bus.v_valid),
    .v_pass    (bus.v_pass),
    .v_pkt     (bus.v_pkt),
    .unexp     (bus.unexp),
    .pkt_cnt   (bus.pkt_cnt),
    .err_cnt   (bus.err_cnt)
  );

endmodule

// File: tb/tb_exdes_icrc_chk_sched.sv
// Directed bench for exdes_icrc_chk_sched with a queue-based reference model
// checked on every falling clock edge, plus hand-computed literal checks.
module tb_exdes_icrc_chk_sched;

  localparam int W    = 3;
  localparam int POOL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  exdes_icrc_chk_sched_if #(.C_PKT_NUM_WIDTH(W)) bus ();

  exdes_icrc_chk_sched #(.C_PKT_NUM_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_q[$];          // outstanding tags, oldest first
  bit          m_done[POOL];
  bit          m_err[POOL];
  int          m_wr, m_rd, m_cur;
  bit          m_in_pkt, m_unexp;
  longint      m_pkt_cnt, m_err_cnt;
  bit          m_c_valid, m_c_first, m_c_last;
  int          m_c_pkt;
  logic [511:0] m_c_data;
  logic [63:0]  m_c_keep;

  function automatic bit exp_ready();
    return !(!m_in_pkt && m_q.size() == POOL);
  endfunction

  function automatic bit exp_vvalid();
    return (m_q.size() > 0) && m_done[m_q[0]];
  endfunction

  function automatic bit in_q(input int t);
    foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, rel;
    int front, rt;
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < POOL; i++) begin m_done[i] = 0; m_err[i] = 0; end
      m_wr = 0; m_rd = 0; m_cur = 0; m_in_pkt = 0; m_unexp = 0;
      m_pkt_cnt = 0; m_err_cnt = 0;
      m_c_valid = 0; m_c_first = 0; m_c_last = 0; m_c_pkt = 0;
      m_c_data = '0; m_c_keep = '0;
    end else begin
      acc = bus.s_tvalid && exp_ready();
      rel = exp_vvalid() && bus.v_ready;
      if (bus.r_valid) begin
        rt = int'(bus.r_pkt);
        if (in_q(rt) && !m_done[rt]) begin
          m_done[rt] = 1; m_err[rt] = bus.r_err;
        end else m_unexp = 1;
      end
      if (rel) begin
        front = m_q.pop_front();
        m_done[front] = 0;
        if (m_pkt_cnt < 64'hFFFF_FFFF) m_pkt_cnt++;
        if (m_err[front] && m_err_cnt < 64'hFFFF_FFFF) m_err_cnt++;
        m_rd = (m_rd + 1) % POOL;
      end
      m_c_valid = acc;
      m_c_first = acc && !m_in_pkt;
      m_c_last  = acc && bus.s_tlast;
      if (acc) begin
        m_c_data = bus.s_tdata;
        m_c_keep = bus.s_tkeep;
        m_c_pkt  = m_in_pkt ? m_cur : m_wr;
        if (!m_in_pkt) begin
          m_cur = m_wr;
          m_q.push_back(m_wr);
          m_done[m_wr] = 0; m_err[m_wr] = 0;
          m_wr = (m_wr + 1) % POOL;
        end
        m_in_pkt = !bus.s_tlast;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_tready", bus.s_tready, exp_ready());
      chk("c_valid", bus.c_valid, m_c_valid);
      if (m_c_valid) begin
        chk("c_first", bus.c_first, m_c_first);
        chk("c_last",  bus.c_last,  m_c_last);
        chk("c_pkt",   bus.c_pkt,   m_c_pkt[W-1:0]);
        chk("c_data",  bus.c_data,  m_c_data);
        chk("c_keep",  bus.c_keep,  m_c_keep);
      end
      chk("v_valid", bus.v_valid, exp_vvalid());
      if (exp_vvalid()) begin
        chk("v_pass", bus.v_pass, !m_err[m_q[0]]);
        chk("v_pkt",  bus.v_pkt,  m_rd[W-1:0]);
      end
      chk("unexp",   bus.unexp,   m_unexp);
      chk("pkt_cnt", bus.pkt_cnt, m_pkt_cnt[31:0]);
      chk("err_cnt", bus.err_cnt, m_err_cnt[31:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.s_tvalid = 0; bus.s_tlast = 0; bus.s_tdata = '0; bus.s_tkeep = '0;
    bus.r_valid = 0; bus.r_pkt = '0; bus.r_err = 0; bus.v_ready = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.s_tready && n < 50) begin tick(); n++; end
    if (n == 50) chk("ready_timeout", bus.s_tready, 1'b1);
  endtask

  task automatic send_pkt(input int nb, input int seed, output int first_tag);
    first_tag = -1;
    for (int b = 0; b < nb; b++) begin
      bus.s_tvalid = 1;
      bus.s_tdata  = {16{32'(seed * 16 + b)}};
      bus.s_tlast  = (b == nb - 1);
      bus.s_tkeep  = (b == nb - 1 && nb > 1) ? 64'h0000_0000_FFFF_FFFF : '1;
      wait_ready();
      tick();
      if (b == 0) first_tag = int'(bus.c_pkt);
    end
    bus.s_tvalid = 0; bus.s_tlast = 0;
  endtask

  task automatic ret(input int tag, input bit err);
    bus.r_valid = 1; bus.r_pkt = W'(tag); bus.r_err = err;
    tick();
    bus.r_valid = 0; bus.r_err = 0;
  endtask

  task automatic accept_verdict(input int exp_pkt, input bit exp_pass);
    int n = 0;
    while (!bus.v_valid && n < 50) begin tick(); n++; end
    if (n == 50) chk("verdict_timeout", bus.v_valid, 1'b1);
    chk("verdict_pkt",  bus.v_pkt,  exp_pkt);
    chk("verdict_pass", bus.v_pass, exp_pass);
    bus.v_ready = 1;
    tick();
    bus.v_ready = 0;
  endtask

  task automatic do_reset();
    #1 rst_n = 0;
    idle_inputs();
    #1;
    chk("rst_tready", bus.s_tready, 1'b1);
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tg;
    idle_inputs();
    do_reset();

    // reset values
    chk("rst_c_valid", bus.c_valid, 1'b0);
    chk("rst_v_valid", bus.v_valid, 1'b0);
    chk("rst_unexp",   bus.unexp,   1'b0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 32'd0);
    chk("rst_err_cnt", bus.err_cnt, 32'd0);
    chk("rst_ready",   bus.s_tready, 1'b1);

    // single-beat packet, result five cycles after c_valid
    send_pkt(1, 1, tg);
    chk("single_c_valid", bus.c_valid, 1'b1);
    chk("single_c_first", bus.c_first, 1'b1);
    chk("single_c_last",  bus.c_last,  1'b1);
    chk("single_c_keep",  bus.c_keep,  64'hFFFF_FFFF_FFFF_FFFF);
    chk("single_tag",     tg, 0);
    repeat (5) tick();
    ret(0, 0);
    chk("single_v_valid", bus.v_valid, 1'b1);
    chk("single_v_pass",  bus.v_pass,  1'b1);
    chk("single_v_pkt",   bus.v_pkt,   3'd0);
    accept_verdict(0, 1);
    chk("single_pkt_cnt", bus.pkt_cnt, 32'd1);
    chk("single_err_cnt", bus.err_cnt, 32'd0);

    // fill the pool with eight 3-beat packets
    do_reset();
    for (int k = 0; k < POOL; k++) begin
      send_pkt(3, 16 + k, tg);
      chk("fill_tag", tg, k);
    end
    bus.s_tvalid = 1; bus.s_tlast = 0; bus.s_tkeep = '1;
    bus.s_tdata  = {16{32'hA5A5_0000}};
    #1;
    chk("full_stall", bus.s_tready, 1'b0);
    tick(); tick();
    chk("full_stall_hold", bus.s_tready, 1'b0);
    ret(0, 0);
    chk("full_head_valid", bus.v_valid, 1'b1);
    bus.v_ready = 1;
    tick();
    bus.v_ready = 0;
    chk("ready_after_release", bus.s_tready, 1'b1);
    tick();
    chk("ninth_tag",   bus.c_pkt,   3'd0);
    chk("ninth_first", bus.c_first, 1'b1);
    bus.s_tdata = {16{32'hA5A5_0001}};
    tick();
    bus.s_tdata = {16{32'hA5A5_0002}}; bus.s_tlast = 1;
    tick();
    bus.s_tvalid = 0; bus.s_tlast = 0;
    for (int t = 1; t <= POOL; t++) ret(t % POOL, 0);
    for (int t = 1; t <= POOL; t++) accept_verdict(t % POOL, 1);
    chk("fill_pkt_cnt", bus.pkt_cnt, 32'd9);

    // out-of-order results, in-order release
    do_reset();
    for (int k = 0; k < 3; k++) send_pkt(1, 40 + k, tg);
    ret(2, 0);
    chk("ooo_hold", bus.v_valid, 1'b0);
    ret(0, 1);
    ret(1, 0);
    accept_verdict(0, 0);
    accept_verdict(1, 1);
    accept_verdict(2, 1);
    chk("ooo_err_cnt", bus.err_cnt, 32'd1);
    chk("ooo_pkt_cnt", bus.pkt_cnt, 32'd3);

    // verdict held while v_ready is low
    send_pkt(1, 50, tg);
    chk("hold_tag", tg, 3);
    ret(3, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_v_valid", bus.v_valid, 1'b1);
      chk("hold_v_pass",  bus.v_pass,  1'b0);
      chk("hold_v_pkt",   bus.v_pkt,   3'd3);
      chk("hold_pkt_cnt", bus.pkt_cnt, 32'd3);
      chk("hold_err_cnt", bus.err_cnt, 32'd1);
      tick();
    end
    accept_verdict(3, 0);
    chk("hold_pkt_cnt_after", bus.pkt_cnt, 32'd4);
    chk("hold_err_cnt_after", bus.err_cnt, 32'd2);

    // unexpected result for a free tag
    do_reset();
    send_pkt(1, 60, tg);
    send_pkt(1, 61, tg);
    ret(5, 0);
    chk("unexp_set",  bus.unexp,   1'b1);
    chk("unexp_nov",  bus.v_valid, 1'b0);
    repeat (3) tick();
    chk("unexp_sticky", bus.unexp, 1'b1);
    ret(0, 0);
    accept_verdict(0, 1);
    chk("unexp_pkt_cnt", bus.pkt_cnt, 32'd1);

    // reset in the middle of a packet tagged 3
    send_pkt(1, 62, tg);
    chk("mid_prev_tag", tg, 2);
    ret(1, 0);
    bus.s_tvalid = 1; bus.s_tlast = 0; bus.s_tkeep = '1;
    bus.s_tdata = {16{32'h0BAD_0000}};
    tick();
    chk("mid_tag", bus.c_pkt, 3'd3);
    bus.s_tdata = {16{32'h0BAD_0001}};
    #2 rst_n = 0;
    #1;
    chk("mid_rst_c_valid", bus.c_valid, 1'b0);
    chk("mid_rst_c_pkt",   bus.c_pkt,   3'd0);
    chk("mid_rst_c_data",  bus.c_data,  512'd0);
    chk("mid_rst_v_valid", bus.v_valid, 1'b0);
    chk("mid_rst_unexp",   bus.unexp,   1'b0);
    chk("mid_rst_pkt_cnt", bus.pkt_cnt, 32'd0);
    chk("mid_rst_ready",   bus.s_tready, 1'b1);
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    send_pkt(2, 70, tg);
    chk("post_rst_tag", tg, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
